idli_sqi_arb_m: RTL and testbench
=================================

Name: idli_sqi_arb_m

Overview:
- Sequencer and arbiter for one SQI memory channel, shared between the instruction-fetch requester (slot 0) and the data load/store requester (slot 1).
- Selects a requester round-robin, then drives the full SQI transaction itself: command, address, dummy (reads only), data, deselect.
- Sits between the core (PC/fetch and execute) and the SQI pads.
- Moves read data nibbles back to the granted requester and pulls write nibbles from the data requester.

Parameters:
- ADDR_NIBBLES, 4, number of address nibbles sent, most significant first.
- DATA_NIBBLES, 4, number of data nibbles per transaction (one 16-bit word).

Ports:
- i_arb_gck  in  1  core clock; all state updates on rising edge.
- i_arb_rst  in  1  asynchronous, active-high reset.
- i_arb_req  in  2  request; [0]=fetch, [1]=data; level, held until granted.
- i_arb_data_wr  in  1  data requester operation: 1=write, 0=read; fetch is always a read.
- i_arb_addr_fetch  in  4*ADDR_NIBBLES  fetch address.
- i_arb_addr_data  in  4*ADDR_NIBBLES  data address.
- o_arb_gnt  out  2  one-hot grant pulse; address and operation are sampled this cycle.
- i_arb_wr_data  in  4  write nibble from the data requester.
- o_arb_wr_acp  out  1  i_arb_wr_data consumed this cycle.
- o_arb_rd_data  out  4  registered read nibble.
- o_arb_rd_vld  out  2  one-hot: o_arb_rd_data valid for that requester.
- o_arb_done  out  2  one-hot transaction-complete pulse.
- o_arb_cs  out  1  chip select, active low.
- o_arb_sck_en  out  1  enables SCK toggling.
- o_arb_sio  out  4  nibble driven to memory.
- o_arb_sio_oe  out  1  1 = core drives SIO.
- i_arb_sio  in  4  nibble from memory.
- i_arb_fetch_hold  in  1  fetch burst continuation; used only with IDLI_SQI_ARB_BURST_EN.

Behaviour:
- Reset values (asynchronous on i_arb_rst, immediate including mid-transaction):
  - state=IDLE, o_arb_cs=1, o_arb_sck_en=0, o_arb_sio_oe=0, o_arb_sio=0.
  - o_arb_gnt=0, o_arb_rd_vld=0, o_arb_done=0, o_arb_wr_acp=0, o_arb_rd_data=0.
  - last-grant pointer = fetch, so the first contended grant goes to data.
- States: IDLE -> CMD(2) -> ADDR(ADDR_NIBBLES) -> DUMMY(2, reads only) -> DATA(DATA_NIBBLES) -> END(1) -> IDLE. A single down-counter sized for the longest phase tracks progress within a phase.
- IDLE:
  - Any request present: pulse o_arb_gnt, latch owner, address and operation, enter CMD next cycle.
  - Both requesting: grant the requester not granted last; pointer updates on every grant.
  - A request dropped before grant is legal and is ignored. i_arb_req of the owner is ignored after grant until END.
- CMD: o_arb_cs=0, o_arb_sck_en=1, o_arb_sio_oe=1. o_arb_sio = 0x0 then 0x3 (read) or 0x0 then 0x2 (write).
- ADDR: latched address driven most significant nibble first, oe=1.
- DUMMY: oe=0, 2 cycles.
- DATA (read): oe=0. i_arb_sio is registered each cycle into o_arb_rd_data; o_arb_rd_vld[owner] is set one cycle later, so the last read nibble appears in END.
- DATA (write): oe=1, o_arb_sio=i_arb_wr_data, o_arb_wr_acp=1 every cycle. The requester must present a new nibble each cycle; there is no backpressure.
- END: cs=1, sck_en=0, oe=0, o_arb_done[owner]=1 for one cycle.
- Cycle counts: CS low for 2+ADDR_NIBBLES+2+DATA_NIBBLES cycles on a read (12 at defaults) and 2+ADDR_NIBBLES+DATA_NIBBLES on a write (10). Minimum CS-high gap is 2 cycles (END + IDLE).
- o_arb_sio holds its last value whenever oe=0.

Optional Feature:
- Macro: IDLI_SQI_ARB_BURST_EN.
- Defined, at the last DATA nibble of a fetch read:
  - If i_arb_fetch_hold=1 and i_arb_req[1]=0, the block stays in DATA for another DATA_NIBBLES, keeping CS low.
  - The memory streams the sequential word; no CMD, ADDR or DUMMY phases are repeated.
  - o_arb_done is not pulsed between words.
  - A data request, or hold=0, at that point ends the burst through END as normal.
- Undefined: i_arb_fetch_hold is ignored and every fetch is a single word.

Test Plan:
- Fetch read, addr 0x1234, memory returns nibbles A,B,C,D:
  - o_arb_sio = 0,3,1,2,3,4 with oe=1, then 2 dummy cycles with oe=0.
  - o_arb_rd_vld[0] pulses with A,B,C,D; o_arb_done=01 in END; 12 CS-low cycles.
- Data write, addr 0xBEEF, wr nibbles 5,6,7,8 -> sio = 0,2,B,E,E,F,5,6,7,8; wr_acp high for 4 cycles; done=10; 10 CS-low cycles.
- Both requests from reset in the same cycle -> gnt=10 first, then gnt=01 after END+IDLE; with both held, grants alternate 10,01,10.
- Reset asserted during ADDR phase -> o_arb_cs=1 and oe=0 asynchronously. After release, a fresh fetch restarts from CMD with nibble 0x0.
- Request at fetch withdrawn before grant while the data channel is busy -> no fetch grant, no done pulse for fetch.
- BURST_EN defined, fetch with hold=1 for two words -> CS stays low, 8 rd_vld pulses with no command resend, one done pulse; a data request mid-burst terminates the burst after the current word.

Source files
------------

// File: rtl/idli_sqi_arb_m.sv
// Round-robin arbiter and SQI transaction sequencer for one memory channel shared by fetch (slot 0) and data (slot 1).
// Optional macro IDLI_SQI_ARB_BURST_EN: fetch reads continue with sequential words while i_arb_fetch_hold is high.
`timescale 1ns/1ps

module idli_sqi_arb_m #(
    parameter int ADDR_NIBBLES = 4,
    parameter int DATA_NIBBLES = 4
) (
    input  logic                      i_arb_gck,
    input  logic                      i_arb_rst,
    input  logic [1:0]                i_arb_req,
    input  logic                      i_arb_data_wr,
    input  logic [4*ADDR_NIBBLES-1:0] i_arb_addr_fetch,
    input  logic [4*ADDR_NIBBLES-1:0] i_arb_addr_data,
    output logic [1:0]                o_arb_gnt,
    input  logic [3:0]                i_arb_wr_data,
    output logic                      o_arb_wr_acp,
    output logic [3:0]                o_arb_rd_data,
    output logic [1:0]                o_arb_rd_vld,
    output logic [1:0]                o_arb_done,
    output logic                      o_arb_cs,
    output logic                      o_arb_sck_en,
    output logic [3:0]                o_arb_sio,
    output logic                      o_arb_sio_oe,
    input  logic [3:0]                i_arb_sio,
    input  logic                      i_arb_fetch_hold
);

    localparam int AW        = 4 * ADDR_NIBBLES;
    localparam int MAX_PHASE = (ADDR_NIBBLES > DATA_NIBBLES)
                             ? ((ADDR_NIBBLES > 2) ? ADDR_NIBBLES : 2)
                             : ((DATA_NIBBLES > 2) ? DATA_NIBBLES : 2);
    localparam int CNT_W     = $clog2(MAX_PHASE);

    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LOAD  = CNT_W'(ADDR_NIBBLES - 1);
    localparam logic [CNT_W-1:0] DUMMY_LOAD = CNT_W'(1);
    localparam logic [CNT_W-1:0] DATA_LOAD  = CNT_W'(DATA_NIBBLES - 1);

    localparam logic [3:0] CMD_READ  = 4'h3;
    localparam logic [3:0] CMD_WRITE = 4'h2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_END
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;   // 0 = fetch, 1 = data
    logic             last_q, last_d;     // slot granted most recently
    logic             wr_q, wr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [3:0]       sio_q;
    logic [3:0]       rd_data_q;
    logic [1:0]       rd_vld_q;

    logic [1:0]       gnt_c;
    logic             pick_c;
    logic             cap_rd_c;
    logic [3:0]       sio_c;
    logic [1:0]       owner_oh;

    assign owner_oh = {owner_q, ~owner_q};

`ifndef IDLI_SQI_ARB_BURST_EN
    logic unused_fetch_hold;
    assign unused_fetch_hold = i_arb_fetch_hold;
`endif

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_d       = last_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        gnt_c        = 2'b00;
        pick_c       = 1'b0;
        cap_rd_c     = 1'b0;
        sio_c        = sio_q;
        o_arb_cs     = 1'b1;
        o_arb_sck_en = 1'b0;
        o_arb_sio_oe = 1'b0;
        o_arb_wr_acp = 1'b0;
        o_arb_done   = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                if (|i_arb_req) begin
                    // With both requesting, the slot not granted last wins.
                    pick_c  = (&i_arb_req) ? ~last_q : i_arb_req[1];
                    gnt_c   = pick_c ? 2'b10 : 2'b01;
                    owner_d = pick_c;
                    last_d  = pick_c;
                    wr_d    = pick_c & i_arb_data_wr;
                    addr_d  = pick_c ? i_arb_addr_data : i_arb_addr_fetch;
                    cnt_d   = CMD_LOAD;
                    state_d = ST_CMD;
                end
            end

            ST_CMD: begin
                o_arb_cs     = 1'b0;
                o_arb_sck_en = 1'b1;
                o_arb_sio_oe = 1'b1;
                if (cnt_q == CMD_LOAD) begin
                    sio_c = 4'h0;
                end else begin
                    sio_c = wr_q ? CMD_WRITE : CMD_READ;
                end
                if (cnt_q == '0) begin
                    cnt_d   = ADDR_LOAD;
                    state_d = ST_ADDR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_ADDR: begin
                o_arb_cs     = 1'b0;
                o_arb_sck_en = 1'b1;
                o_arb_sio_oe = 1'b1;
                sio_c        = addr_q[AW-1 -: 4];
                addr_d       = addr_q << 4;
                if (cnt_q == '0) begin
                    if (wr_q) begin
                        cnt_d   = DATA_LOAD;
                        state_d = ST_DATA;
                    end else begin
                        cnt_d   = DUMMY_LOAD;
                        state_d = ST_DUMMY;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_DUMMY: begin
                o_arb_cs     = 1'b0;
                o_arb_sck_en = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = DATA_LOAD;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_DATA: begin
                o_arb_cs     = 1'b0;
                o_arb_sck_en = 1'b1;
                if (wr_q) begin
                    o_arb_sio_oe = 1'b1;
                    o_arb_wr_acp = 1'b1;
                    sio_c        = i_arb_wr_data;
                end else begin
                    cap_rd_c = 1'b1;
                end
                if (cnt_q == '0) begin
`ifdef IDLI_SQI_ARB_BURST_EN
                    // The memory keeps streaming the next word while CS stays low.
                    if (!owner_q && i_arb_fetch_hold && !i_arb_req[1]) begin
                        cnt_d = DATA_LOAD;
                    end else begin
                        state_d = ST_END;
                    end
`else
                    state_d = ST_END;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_END: begin
                o_arb_done = owner_oh;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant is a pure function of the request while idle, so it is masked during reset.
    assign o_arb_gnt     = gnt_c & {2{~i_arb_rst}};
    assign o_arb_sio     = sio_c;
    assign o_arb_rd_data = rd_data_q;
    assign o_arb_rd_vld  = rd_vld_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_arb_gck or posedge i_arb_rst) begin
        if (i_arb_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            last_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            sio_q     <= 4'h0;
            rd_data_q <= 4'h0;
            rd_vld_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            sio_q    <= sio_c;
            rd_vld_q <= cap_rd_c ? owner_oh : 2'b00;
            if (cap_rd_c) begin
                rd_data_q <= i_arb_sio;
            end
        end
    end

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Scoreboard bench for idli_sqi_arb_m: a pin-level memory model plus queues of expected grants, nibbles, read data, done pulses and CS-low lengths.
// Burst expectations follow IDLI_SQI_ARB_BURST_EN when the bench is built with it.
`timescale 1ns/1ps

module tb_idli_sqi_arb_m;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic        data_wr = 1'b0;
    logic [15:0] addr_fetch = 16'h0;
    logic [15:0] addr_data = 16'h0;
    logic [1:0]  gnt;
    logic [3:0]  wr_data = 4'h0;
    logic        wr_acp;
    logic [3:0]  rd_data;
    logic [1:0]  rd_vld;
    logic [1:0]  done;
    logic        cs;
    logic        sck_en;
    logic [3:0]  sio_out;
    logic        sio_oe;
    logic [3:0]  sio_in = 4'h0;
    logic        fetch_hold = 1'b0;

    always #5 clk = ~clk;

    idli_sqi_arb_m #(.ADDR_NIBBLES(4), .DATA_NIBBLES(4)) dut (
        .i_arb_gck        (clk),
        .i_arb_rst        (rst),
        .i_arb_req        (req),
        .i_arb_data_wr    (data_wr),
        .i_arb_addr_fetch (addr_fetch),
        .i_arb_addr_data  (addr_data),
        .o_arb_gnt        (gnt),
        .i_arb_wr_data    (wr_data),
        .o_arb_wr_acp     (wr_acp),
        .o_arb_rd_data    (rd_data),
        .o_arb_rd_vld     (rd_vld),
        .o_arb_done       (done),
        .o_arb_cs         (cs),
        .o_arb_sck_en     (sck_en),
        .o_arb_sio        (sio_out),
        .o_arb_sio_oe     (sio_oe),
        .i_arb_sio        (sio_in),
        .i_arb_fetch_hold (fetch_hold)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [3:0] exp_sio_q[$];
    logic [5:0] exp_rd_q[$];
    logic [1:0] exp_gnt_q[$];
    logic [1:0] exp_done_q[$];
    int         exp_cs_q[$];
    logic [3:0] mem_q[$];
    logic [3:0] wr_q[$];

    int         cs_run = 0;
    int         mon_idx = 0;
    int         acp_cnt = 0;
    logic       cmd_wr = 1'b0;
    logic [3:0] last_sio = 4'h0;

    // Monitor and memory model: sample mid-cycle, then drive the memory's response for the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            cs_run   = 0;
            cmd_wr   = 1'b0;
            last_sio = 4'h0;
            sio_in   = 4'h0;
            wr_data  = 4'h0;
        end else begin
            if (gnt != 2'b00) begin
                if (exp_gnt_q.size() == 0) check("gnt_unexpected", gnt, 0);
                else check("gnt", gnt, exp_gnt_q.pop_front());
            end
            if (done != 2'b00) begin
                if (exp_done_q.size() == 0) check("done_unexpected", done, 0);
                else check("done", done, exp_done_q.pop_front());
            end
            if (rd_vld != 2'b00) begin
                if (exp_rd_q.size() == 0) check("rd_unexpected", rd_vld, 0);
                else check("rd_vld_data", {rd_vld, rd_data}, exp_rd_q.pop_front());
            end
            if (sio_oe) begin
                if (exp_sio_q.size() == 0) begin
                    check("sio_oe_unexpected", sio_oe, 0);
                end else begin
                    last_sio = exp_sio_q.pop_front();
                    check("sio", sio_out, last_sio);
                end
            end else begin
                check("sio_hold", sio_out, last_sio);
            end
            if (wr_acp) acp_cnt++;

            if (!cs) begin
                check("sck_en_cs_low", sck_en, 1);
                mon_idx = cs_run;
                if (mon_idx == 1) cmd_wr = (sio_out == 4'h2);
                cs_run++;
                if (!cmd_wr && mon_idx >= 8) sio_in = (mem_q.size() != 0) ? mem_q.pop_front() : 4'h0;
                if (cmd_wr && mon_idx >= 5 && mon_idx <= 8) wr_data = (wr_q.size() != 0) ? wr_q.pop_front() : 4'h0;
            end else begin
                if (cs_run != 0) begin
                    if (exp_cs_q.size() == 0) check("cs_len_unexpected", cs_run, 0);
                    else check("cs_low_cycles", cs_run, exp_cs_q.pop_front());
                    cs_run = 0;
                end
                cmd_wr = 1'b0;
            end
        end
    end

    task automatic push_read(input logic [1:0] owner, input logic [15:0] addr, input logic [31:0] nibs, input int words);
        exp_gnt_q.push_back(owner);
        exp_sio_q.push_back(4'h0);
        exp_sio_q.push_back(4'h3);
        for (int i = 0; i < 4; i++) exp_sio_q.push_back(addr[15-4*i -: 4]);
        for (int i = 0; i < 4 * words; i++) begin
            logic [31:0] sh;
            sh = nibs >> (4 * (4 * words - 1 - i));
            mem_q.push_back(sh[3:0]);
            exp_rd_q.push_back({owner, sh[3:0]});
        end
        exp_done_q.push_back(owner);
        exp_cs_q.push_back(8 + 4 * words);
    endtask

    task automatic push_write(input logic [15:0] addr, input logic [15:0] nibs);
        exp_gnt_q.push_back(2'b10);
        exp_sio_q.push_back(4'h0);
        exp_sio_q.push_back(4'h2);
        for (int i = 0; i < 4; i++) exp_sio_q.push_back(addr[15-4*i -: 4]);
        for (int i = 0; i < 4; i++) begin
            exp_sio_q.push_back(nibs[15-4*i -: 4]);
            wr_q.push_back(nibs[15-4*i -: 4]);
        end
        exp_done_q.push_back(2'b10);
        exp_cs_q.push_back(10);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one step after the edge that follows the grant cycle.
    task automatic wait_gnt(input int slot);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (gnt[slot]) break;
        end
        if (k == 100) check("gnt_timeout", gnt, 2'b01 << slot);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (cs && exp_gnt_q.size() == 0 && exp_sio_q.size() == 0 && exp_rd_q.size() == 0 &&
                exp_done_q.size() == 0 && exp_cs_q.size() == 0) break;
        end
        if (k == 300) check("drain_timeout", exp_sio_q.size() + exp_rd_q.size() + exp_done_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int acp0;
        cyc(3);
        check("rst_cs", cs, 1);
        check("rst_sck_en", sck_en, 0);
        check("rst_oe", sio_oe, 0);
        check("rst_sio", sio_out, 0);
        check("rst_gnt", gnt, 0);
        check("rst_rd_vld", rd_vld, 0);
        check("rst_done", done, 0);
        check("rst_wr_acp", wr_acp, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        cyc(2);

        // Single fetch read.
        addr_fetch = 16'h1234;
        push_read(2'b01, 16'h1234, 32'h0000_ABCD, 1);
        req = 2'b01;
        wait_gnt(0);
        req = 2'b00;
        drain();

        // Single data write.
        addr_data = 16'hBEEF;
        data_wr   = 1'b1;
        acp0      = acp_cnt;
        push_write(16'hBEEF, 16'h5678);
        req = 2'b10;
        wait_gnt(1);
        req = 2'b00;
        drain();
        check("wr_acp_cycles", acp_cnt - acp0, 4);

        // Simultaneous requests straight out of reset: data wins first.
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        addr_fetch = 16'h0F0F;
        addr_data  = 16'h5555;
        data_wr    = 1'b0;
        push_read(2'b10, 16'h5555, 32'h0000_1234, 1);
        push_read(2'b01, 16'h0F0F, 32'h0000_5678, 1);
        req = 2'b11;
        wait_gnt(1);
        req[1] = 1'b0;
        wait_gnt(0);
        req[0] = 1'b0;
        drain();

        // Both held continuously: grants alternate data, fetch, data.
        addr_fetch = 16'h1234;
        addr_data  = 16'hBEEF;
        data_wr    = 1'b1;
        push_write(16'hBEEF, 16'h1357);
        push_read(2'b01, 16'h1234, 32'h0000_2468, 1);
        push_write(16'hBEEF, 16'h9ACE);
        req = 2'b11;
        wait_gnt(1);
        wait_gnt(0);
        wait_gnt(1);
        req = 2'b00;
        drain();

        // Reset in the middle of the address phase, then a clean restart.
        addr_fetch = 16'h1234;
        exp_gnt_q.push_back(2'b01);
        exp_sio_q.push_back(4'h0);
        exp_sio_q.push_back(4'h3);
        exp_sio_q.push_back(4'h1);
        req = 2'b01;
        wait_gnt(0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        req = 2'b00;
        #1;
        check("midrst_cs", cs, 1);
        check("midrst_oe", sio_oe, 0);
        check("midrst_sck_en", sck_en, 0);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("midrst_sb_sio", exp_sio_q.size(), 0);
        push_read(2'b01, 16'h1234, 32'h0000_FEDC, 1);
        req = 2'b01;
        wait_gnt(0);
        req = 2'b00;
        drain();

        // Fetch request withdrawn while the data transaction owns the channel.
        addr_data = 16'h0A0B;
        data_wr   = 1'b1;
        push_write(16'h0A0B, 16'h3C3C);
        req = 2'b10;
        wait_gnt(1);
        req = 2'b00;
        cyc(2);
        req[0] = 1'b1;
        cyc(3);
        req[0] = 1'b0;
        drain();
        cyc(5);
        check("withdrawn_idle_cs", cs, 1);

        // Fetch with hold asserted, data request arriving during the second word.
        addr_fetch = 16'h2000;
        addr_data  = 16'h0040;
        data_wr    = 1'b0;
        fetch_hold = 1'b1;
`ifdef IDLI_SQI_ARB_BURST_EN
        push_read(2'b01, 16'h2000, 32'h1234_5678, 2);
`else
        push_read(2'b01, 16'h2000, 32'h0000_1234, 1);
`endif
        push_read(2'b10, 16'h0040, 32'h0000_9ABC, 1);
        req = 2'b01;
        wait_gnt(0);
        req = 2'b00;
        repeat (13) @(posedge clk);
        #1;
        req = 2'b10;
        wait_gnt(1);
        req        = 2'b00;
        fetch_hold = 1'b0;
        drain();

        check("sb_empty", exp_gnt_q.size() + exp_sio_q.size() + exp_rd_q.size() +
              exp_done_q.size() + exp_cs_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
